// File: rtl/mmio_pkg.sv
// Shared types, register offsets and reset constants for the board I/O register block.
package mmio_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;

    localparam logic [2:0] MMIO_REG_LED         = 3'd0;
    localparam logic [2:0] MMIO_REG_KEY_STATE   = 3'd1;
    localparam logic [2:0] MMIO_REG_KEY_EVENT   = 3'd2;
    localparam logic [2:0] MMIO_REG_TIMER_COUNT = 3'd3;
    localparam logic [2:0] MMIO_REG_TIMER_CMP   = 3'd4;
    localparam logic [2:0] MMIO_REG_IRQ_STATUS  = 3'd5;
    localparam logic [2:0] MMIO_REG_IRQ_EN      = 3'd6;
    localparam logic [2:0] MMIO_REG_RSVD        = 3'd7;

    localparam data_t READ_DATA_RESET   = 32'h0000_0000;
    localparam data_t TIMER_COUNT_RESET = 32'h0000_0000;
    localparam data_t TIMER_CMP_RESET   = 32'hFFFF_FFFF;

    // Merge new_val into old_val one byte lane at a time.
    function automatic data_t apply_be(input data_t old_val, input data_t new_val,
                                       input logic [3:0] be);
        data_t res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// One push-button channel: 2-flop synchroniser, polarity normalisation and a
// stability counter that accepts a new level after DEBOUNCE_CYCLES stable cycles.
module key_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic          IDLE_PIN = ACTIVE_LOW ? 1'b1 : 1'b0;

    logic [1:0]    sync_q;
    logic          synced;
    logic          level_q, level_d;
    logic          press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Synchroniser resets to the idle pin level so reset release never looks like a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {2{IDLE_PIN}};
        end else begin
            sync_q <= {sync_q[0], raw};
        end
    end

    assign synced = ACTIVE_LOW ? ~sync_q[1] : sync_q[1];

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (synced != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = synced;
                press_d = synced;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_d;

endmodule

// File: rtl/mmio_board_io.sv
// Memory-mapped board I/O: LED register, debounced keys with sticky press flags,
// prescaled timer with compare match, and a registered level interrupt.
module mmio_board_io
    import mmio_pkg::*;
#(
    parameter addr_t       BASE_ADDR       = 32'h0001_0000,
    parameter int unsigned N_LEDS          = 10,
    parameter int unsigned N_KEYS          = 4,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned PRESCALE        = 50
) (
    input  logic              clk,
    input  logic              reset,
    input  addr_t             address,
    input  data_t             write_data,
    input  logic [3:0]        write_enable,
    output data_t             read_data,
    input  logic [N_KEYS-1:0] keys_raw,
    output logic [N_LEDS-1:0] leds,
    output logic              irq
);

    localparam int unsigned   PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    logic       hit;
    logic       wr;
    logic [2:0] offset;

    logic [N_LEDS-1:0] led_q, led_d;
    logic [N_KEYS-1:0] key_level, key_press;
    logic [N_KEYS-1:0] key_event_q, key_event_d;
    logic [PW-1:0]     presc_q, presc_d;
    data_t             count_q, count_d, count_inc;
    data_t             cmp_q, cmp_d;
    logic              tick, match;
    logic              timer_flag_q, timer_flag_d;
    logic [1:0]        irq_en_q, irq_en_d;
    logic              irq_q, irq_d;
    data_t             rdata_q, rdata_d;

    data_t led_word, key_state_word, key_event_word, status_word, irq_en_word;
    data_t led_wr, ev_wr, en_wr;
    logic  unused_bits;

    assign hit    = (address[31:5] == BASE_ADDR[31:5]);
    assign offset = address[4:2];
    assign wr     = hit && (write_enable != 4'b0000);

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        key_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (KEY_ACTIVE_LOW)
        ) u_key (
            .clk  (clk),
            .reset(reset),
            .raw  (keys_raw[g]),
            .level(key_level[g]),
            .press(key_press[g])
        );
    end

    always_comb begin
        led_word                    = '0;
        led_word[N_LEDS-1:0]        = led_q;
        key_state_word              = '0;
        key_state_word[N_KEYS-1:0]  = key_level;
        key_event_word              = '0;
        key_event_word[N_KEYS-1:0]  = key_event_q;
        status_word                 = {30'd0, |key_event_q, timer_flag_q};
        irq_en_word                 = {30'd0, irq_en_q};
    end

    assign led_wr = apply_be(led_word, write_data, write_enable);
    assign ev_wr  = apply_be(key_event_word, key_event_word & ~write_data, write_enable);
    assign en_wr  = apply_be(irq_en_word, write_data, write_enable);

    assign tick      = (presc_q == PRESC_MAX);
    assign count_inc = count_q + 32'd1;
    // Compare against the CMP value held before any same-edge write.
    assign match     = tick && (count_inc == cmp_q);

    always_comb begin
        led_d        = led_q;
        cmp_d        = cmp_q;
        irq_en_d     = irq_en_q;
        key_event_d  = key_event_q;
        timer_flag_d = timer_flag_q;
        presc_d      = tick ? '0 : presc_q + 1'b1;
        count_d      = tick ? count_inc : count_q;

        if (wr) begin
            case (offset)
                MMIO_REG_LED:        led_d       = led_wr[N_LEDS-1:0];
                MMIO_REG_KEY_EVENT:  key_event_d = ev_wr[N_KEYS-1:0];
                MMIO_REG_TIMER_CMP:  cmp_d       = apply_be(cmp_q, write_data, write_enable);
                MMIO_REG_IRQ_STATUS: begin
                    if (write_enable[0] && write_data[0]) begin
                        timer_flag_d = 1'b0;
                    end
                end
                MMIO_REG_IRQ_EN:     irq_en_d    = en_wr[1:0];
                default:             ;
            endcase
        end

        // New events override a same-edge clear.
        key_event_d = key_event_d | key_press;
        if (match) begin
            timer_flag_d = 1'b1;
        end

        irq_d = (timer_flag_q & irq_en_q[0]) | ((|key_event_q) & irq_en_q[1]);
    end

    always_comb begin
        rdata_d = rdata_q;
        if (hit) begin
            case (offset)
                MMIO_REG_LED:         rdata_d = led_word;
                MMIO_REG_KEY_STATE:   rdata_d = key_state_word;
                MMIO_REG_KEY_EVENT:   rdata_d = key_event_word;
                MMIO_REG_TIMER_COUNT: rdata_d = count_q;
                MMIO_REG_TIMER_CMP:   rdata_d = cmp_q;
                MMIO_REG_IRQ_STATUS:  rdata_d = status_word;
                MMIO_REG_IRQ_EN:      rdata_d = irq_en_word;
                MMIO_REG_RSVD:        rdata_d = '0;
                default:              rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q        <= '0;
            key_event_q  <= '0;
            presc_q      <= '0;
            count_q      <= TIMER_COUNT_RESET;
            cmp_q        <= TIMER_CMP_RESET;
            timer_flag_q <= 1'b0;
            irq_en_q     <= '0;
            irq_q        <= 1'b0;
            rdata_q      <= READ_DATA_RESET;
        end else begin
            led_q        <= led_d;
            key_event_q  <= key_event_d;
            presc_q      <= presc_d;
            count_q      <= count_d;
            cmp_q        <= cmp_d;
            timer_flag_q <= timer_flag_d;
            irq_en_q     <= irq_en_d;
            irq_q        <= irq_d;
            rdata_q      <= rdata_d;
        end
    end

    assign read_data = rdata_q;
    assign leds      = led_q;
    assign irq       = irq_q;

    // Byte-offset bits and the unused upper lanes of the merge results are don't-care.
    assign unused_bits = ^{address[1:0], led_wr, ev_wr, en_wr};

endmodule

// File: tb/tb_mmio_board_io.sv
// Directed bench for mmio_board_io with DEBOUNCE_CYCLES=4 and PRESCALE=2.
module tb_mmio_board_io;
    import mmio_pkg::*;

    localparam addr_t BASE = 32'h0001_0000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    addr_t      address = BASE;
    data_t      write_data = '0;
    logic [3:0] write_enable = 4'b0000;
    data_t      read_data;
    logic [3:0] keys_raw = 4'hF;
    logic [9:0] leds;
    logic       irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mmio_board_io #(
        .BASE_ADDR      (BASE),
        .N_LEDS         (10),
        .N_KEYS         (4),
        .KEY_ACTIVE_LOW (1'b1),
        .DEBOUNCE_CYCLES(4),
        .PRESCALE       (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .write_data  (write_data),
        .write_enable(write_enable),
        .read_data   (read_data),
        .keys_raw    (keys_raw),
        .leds        (leds),
        .irq         (irq)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put_addr(input logic [2:0] off);
        address      = {BASE[31:5], off, 2'b00};
        write_enable = 4'b0000;
    endtask

    task automatic wr(input logic [2:0] off, input data_t data, input logic [3:0] be);
        address      = {BASE[31:5], off, 2'b00};
        write_data   = data;
        write_enable = be;
        step(1);
        write_enable = 4'b0000;
    endtask

    task automatic rd(input logic [2:0] off, output data_t v);
        put_addr(off);
        step(1);
        v = read_data;
    endtask

    // Reset with TIMER_COUNT addressed so the first edge after release reads it.
    task automatic do_reset();
        reset        = 1'b1;
        keys_raw     = 4'hF;
        write_enable = 4'b0000;
        write_data   = '0;
        put_addr(3'd3);
        step(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        data_t v;
        data_t exp_tab [8];
        exp_tab = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
        do_reset();
        checks++;
        if (leds !== 10'h000 || irq !== 1'b0 || read_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: leds=%h irq=%b rdata=%h want 0 0 0", leds, irq, read_data);
        end
        step(1);
        checks++;
        if (read_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_timer_count: got %h want 00000000", read_data);
        end
        for (int i = 0; i < 8; i++) begin
            if (i != 3) begin
                rd(3'(i), v);
                checks++;
                if (v !== exp_tab[i]) begin
                    errors++;
                    $display("FAIL reset_read_off%0d: got %h want %h", i, v, exp_tab[i]);
                end
            end
        end
    endtask

    task automatic test_led();
        data_t v;
        wr(3'd0, 32'h0000_03A5, 4'b0001);
        checks++;
        if (leds !== 10'h0A5) begin
            errors++;
            $display("FAIL led_byte0: got %h want 0a5", leds);
        end
        wr(3'd0, 32'h0000_0300, 4'b0010);
        checks++;
        if (leds !== 10'h3A5) begin
            errors++;
            $display("FAIL led_byte1: got %h want 3a5", leds);
        end
        rd(3'd0, v);
        checks++;
        if (v !== 32'h0000_03A5) begin
            errors++;
            $display("FAIL led_readback: got %h want 000003a5", v);
        end
        // Read and write of the same register on one edge.
        write_data   = 32'h0000_00FF;
        write_enable = 4'b1111;
        step(1);
        write_enable = 4'b0000;
        checks++;
        if (read_data !== 32'h0000_03A5 || leds !== 10'h0FF) begin
            errors++;
            $display("FAIL led_rd_during_wr: rdata=%h leds=%h want 000003a5 0ff", read_data, leds);
        end
        step(1);
        checks++;
        if (read_data !== 32'h0000_00FF) begin
            errors++;
            $display("FAIL led_after_wr: got %h want 000000ff", read_data);
        end
        // Outside the window: no write, read data holds.
        address      = BASE + 32'h20;
        write_data   = 32'h0;
        write_enable = 4'b1111;
        step(1);
        write_enable = 4'b0000;
        checks++;
        if (leds !== 10'h0FF || read_data !== 32'h0000_00FF) begin
            errors++;
            $display("FAIL led_out_of_window: leds=%h rdata=%h want 0ff 000000ff", leds, read_data);
        end
        wr(3'd1, 32'hFFFF_FFFF, 4'b1111);
        rd(3'd1, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL ro_write_ignored: got %h want 00000000", v);
        end
    endtask

    task automatic test_key_glitch();
        data_t v;
        keys_raw[2] = 1'b0;
        step(3);
        keys_raw[2] = 1'b1;
        step(8);
        rd(3'd1, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL glitch_state: got %h want 00000000", v);
        end
        rd(3'd2, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL glitch_event: got %h want 00000000", v);
        end
    endtask

    task automatic test_key_press();
        data_t v;
        put_addr(3'd1);
        keys_raw[2] = 1'b0;
        step(6);
        checks++;
        if (read_data !== 32'h0) begin
            errors++;
            $display("FAIL press_early: got %h want 00000000", read_data);
        end
        step(1);
        checks++;
        if (read_data !== 32'h4) begin
            errors++;
            $display("FAIL press_latency: got %h want 00000004", read_data);
        end
        step(3);
        rd(3'd2, v);
        checks++;
        if (v !== 32'h4) begin
            errors++;
            $display("FAIL press_event: got %h want 00000004", v);
        end
        keys_raw[2] = 1'b1;
        step(7);
        rd(3'd1, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL release_state: got %h want 00000000", v);
        end
        rd(3'd2, v);
        checks++;
        if (v !== 32'h4 || irq !== 1'b0) begin
            errors++;
            $display("FAIL release_event: event=%h irq=%b want 00000004 0", v, irq);
        end
        wr(3'd2, 32'h4, 4'b1111);
        rd(3'd2, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL event_w1c: got %h want 00000000", v);
        end
    endtask

    task automatic test_key_irq();
        data_t v;
        wr(3'd6, 32'h2, 4'b1111);
        keys_raw[0] = 1'b0;
        step(6);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL key_irq_early: got %b want 0", irq);
        end
        step(1);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL key_irq_rise: got %b want 1", irq);
        end
        rd(3'd5, v);
        checks++;
        if (v !== 32'h2) begin
            errors++;
            $display("FAIL key_irq_status: got %h want 00000002", v);
        end
        keys_raw[0] = 1'b1;
        step(8);
        // Second press on key1, cleared with W1C on its accept edge.
        keys_raw[1] = 1'b0;
        step(5);
        wr(3'd2, 32'h3, 4'b1111);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL w1c_set_irq_a: got %b want 1", irq);
        end
        rd(3'd2, v);
        checks++;
        if (v !== 32'h2 || irq !== 1'b1) begin
            errors++;
            $display("FAIL w1c_set_wins: event=%h irq=%b want 00000002 1", v, irq);
        end
        keys_raw[1] = 1'b1;
        step(8);
        wr(3'd2, 32'hF, 4'b1111);
        step(1);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL key_irq_clear: got %b want 0", irq);
        end
        wr(3'd6, 32'h0, 4'b1111);
    endtask

    task automatic test_timer();
        data_t v;
        do_reset();
        wr(3'd4, 32'h5, 4'b1111);
        wr(3'd6, 32'h1, 4'b1111);
        step(8);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL timer_irq_early: got %b want 0", irq);
        end
        step(1);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL timer_irq_rise: got %b want 1", irq);
        end
        rd(3'd5, v);
        checks++;
        if (v !== 32'h1) begin
            errors++;
            $display("FAIL timer_status: got %h want 00000001", v);
        end
        rd(3'd3, v);
        checks++;
        if (v !== 32'h6) begin
            errors++;
            $display("FAIL timer_count: got %h want 00000006", v);
        end
        wr(3'd5, 32'h1, 4'b1111);
        step(1);
        rd(3'd5, v);
        checks++;
        if (v !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL timer_w1c: status=%h irq=%b want 00000000 0", v, irq);
        end
    endtask

    task automatic test_timer_wrap();
        data_t v;
        bit    seen_zero;
        seen_zero = 1'b0;
        put_addr(3'd3);
        force dut.count_q = 32'hFFFF_FFFF;
        step(1);
        release dut.count_q;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (read_data == 32'h0) begin
                seen_zero = 1'b1;
                break;
            end
        end
        checks++;
        if (seen_zero !== 1'b1) begin
            errors++;
            $display("FAIL timer_wrap: last count %h, never read 00000000", read_data);
        end
        rd(3'd5, v);
        checks++;
        if (v !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL timer_wrap_no_flag: status=%h irq=%b want 00000000 0", v, irq);
        end
    endtask

    initial begin
        test_reset();
        test_led();
        test_key_glitch();
        test_key_press();
        test_key_irq();
        test_timer();
        test_timer_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
